// File: rtl/ring_johnson_counter.sv
// ring_johnson_counter: a shift counter that runs as a one-hot ring or a
// Johnson (twisted ring) counter, in either direction. It has a synchronous
// parallel load, a registered wrap pulse, and a combinational legality flag.
// Optional self-correction is compiled in with the macro
// RING_JOHNSON_SELF_CORRECT_EN. When it is enabled, an advance from an
// illegal state reloads START.
module ring_johnson_counter #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             cp,
   input  logic             reset,
   input  logic             en,
   input  logic             dir,
   input  logic             mode,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] out,
   output logic             wrap,
   output logic             illegal
);

   localparam int unsigned      CW    = $clog2(WIDTH + 1);
   localparam logic [WIDTH-1:0] START = {1'b1, {(WIDTH - 1){1'b0}}};

   logic [CW-1:0]    ones;
   logic [CW-1:0]    edges;
   logic [WIDTH-1:0] shifted;
   logic [WIDTH-1:0] next_adv;

   // Legality of the present state under the current mode: one-hot for ring, at most one bit boundary for Johnson
   always_comb begin
      ones  = '0;
      edges = '0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
         ones = ones + CW'(out[i]);
      end
      for (int unsigned i = 0; i < WIDTH - 1; i++) begin
         edges = edges + CW'(out[i] ^ out[i+1]);
      end
      if (mode) begin
         illegal = (edges > CW'(1));
      end else begin
         illegal = (ones != CW'(1));
      end
   end

   // One-step shift; the bit that wraps around is inverted in Johnson mode (mode=1)
   always_comb begin
      if (dir) begin
         shifted = {out[WIDTH-2:0], mode ^ out[WIDTH-1]};
      end else begin
         shifted = {mode ^ out[0], out[WIDTH-1:1]};
      end
   end

   // Value taken on an advance edge, with optional recovery from illegal states
   always_comb begin
`ifdef RING_JOHNSON_SELF_CORRECT_EN
      next_adv = illegal ? START : shifted;
`else
      next_adv = shifted;
`endif
   end

   // Counter state and wrap pulse; priority is reset, then load, then advance
   always_ff @(posedge cp or posedge reset) begin
      if (reset) begin
         out  <= START;
         wrap <= 1'b0;
      end else if (load) begin
         out  <= load_val;
         wrap <= 1'b0;
      end else if (en) begin
         out  <= next_adv;
         wrap <= (next_adv == START);
      end else begin
         wrap <= 1'b0;
      end
   end

endmodule
